pb_event_decoder: RTL and testbench

- Input-side counterpart to the LED drivers: conditions the raw, active-low FPGA_PB push-buttons into clean, debounced button state and discrete events.
- Per button: 2-flop synchronizer, debounce filter, press/release edge detection and long-press detection.
- Events are queued in a small FIFO and handed to consumer logic (LED sequencers, mode control) over a valid/ready interface.

---
 rtl/pb_event_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_pb_event_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pb_event_decoder.sv
// pb_event_decoder: conditions raw active-low push-buttons into debounced
// levels plus press / release / long-press events, queued in a small FIFO.
//
// Ports:
//   REFCLK_3B0    in   system clock, rising edge
//   FPGA_RST_n    in   asynchronous active-low reset
//   FPGA_PB       in   raw buttons, active-low, asynchronous to the clock
//   pb_level      out  debounced button state, 1 = pressed
//   evt_valid     out  event FIFO non-empty
//   evt_ready     in   consumer accepts the head event
//   evt_id        out  button index of the head event
//   evt_code      out  01 press, 10 release, 11 long-press
//   evt_overflow  out  sticky flag: an event was dropped
//   ovf_clear     in   synchronous clear of evt_overflow
module pb_event_decoder #(
  parameter int unsigned NUM_PB            = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned LONG_PRESS_CYCLES = 25000000,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                                          REFCLK_3B0,
  input  logic                                          FPGA_RST_n,
  input  logic [NUM_PB-1:0]                             FPGA_PB,
  output logic [NUM_PB-1:0]                             pb_level,
  output logic                                          evt_valid,
  input  logic                                          evt_ready,
  output logic [((NUM_PB > 1) ? $clog2(NUM_PB) : 1)-1:0] evt_id,
  output logic [1:0]                                    evt_code,
  output logic                                          evt_overflow,
  input  logic                                          ovf_clear
);

  localparam int unsigned ID_W   = (NUM_PB > 1) ? $clog2(NUM_PB) : 1;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W  = ID_W + 2;
  localparam int unsigned NFLAG  = 3 * NUM_PB;

  // Synchronizer, reset to the released (high) level
  logic [NUM_PB-1:0] sync1_q, sync2_q;

  // Debounce and hold state
  logic [NUM_PB-1:0] pb_level_q, pb_level_d;
  logic [NUM_PB-1:0] level_prev_q;
  logic [DB_W-1:0]   db_cnt_q   [NUM_PB];
  logic [DB_W-1:0]   db_cnt_d   [NUM_PB];
  logic [HOLD_W-1:0] hold_q     [NUM_PB];
  logic [HOLD_W-1:0] hold_d     [NUM_PB];

  // Pending flags: bit 3*i+0 press, 3*i+1 long, 3*i+2 release
  logic [NFLAG-1:0] pend_q, pend_d;
  logic [NFLAG-1:0] set_c, grant_c, collide_c;

  // FIFO state
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt_c;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ENT_W-1:0] head_q, head_d, push_data_c;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             found_c, push_c, pop_c;

  // Two-flop synchronizer
  always_ff @(posedge REFCLK_3B0 or negedge FPGA_RST_n) begin
    if (!FPGA_RST_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= FPGA_PB;
      sync2_q <= sync1_q;
    end
  end

  // Debounce filter and long-press hold counter
  always_comb begin
    pb_level_d = pb_level_q;
    set_c      = '0;
    for (int i = 0; i < int'(NUM_PB); i++) begin
      db_cnt_d[i] = '0;
      hold_d[i]   = '0;
      if (~sync2_q[i] != pb_level_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          pb_level_d[i] = ~pb_level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
      if (pb_level_q[i]) begin
        if (hold_q[i] != HOLD_W'(LONG_PRESS_CYCLES)) begin
          hold_d[i] = hold_q[i] + HOLD_W'(1);
        end else begin
          hold_d[i] = hold_q[i];
        end
      end
      // Event conditions; the long hit coincides with the counter reaching the threshold
      set_c[3*i]   = pb_level_q[i] & ~level_prev_q[i];
      set_c[3*i+1] = pb_level_q[i] & (hold_q[i] == HOLD_W'(LONG_PRESS_CYCLES - 1));
      set_c[3*i+2] = ~pb_level_q[i] & level_prev_q[i];
    end
  end

  // Fixed-priority arbiter: lowest flag index wins (button, then press > long > release)
  always_comb begin
    found_c     = 1'b0;
    grant_c     = '0;
    push_data_c = '0;
    for (int i = 0; i < int'(NUM_PB); i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!found_c && pend_q[3*i+j]) begin
          found_c          = 1'b1;
          grant_c[3*i+j]   = 1'b1;
          push_data_c[ENT_W-1:2] = ID_W'(i);
          push_data_c[1:0] = (j == 0) ? 2'b01 : ((j == 1) ? 2'b11 : 2'b10);
        end
      end
    end
  end

  assign pop_c  = valid_q & evt_ready;
  assign push_c = found_c & ((count_q != CNT_W'(FIFO_DEPTH)) | pop_c);

  // Pending flags: a granted flag clears; a new event on a still-pending flag is lost
  always_comb begin
    pend_d    = pend_q;
    collide_c = '0;
    for (int k = 0; k < int'(NFLAG); k++) begin
      if (push_c && grant_c[k]) begin
        pend_d[k] = 1'b0;
      end else if (set_c[k] && pend_q[k]) begin
        collide_c[k] = 1'b1;
      end
      if (set_c[k]) begin
        pend_d[k] = 1'b1;
      end
    end
    ovf_d = (|collide_c) ? 1'b1 : (ovf_clear ? 1'b0 : ovf_q);
  end

  // FIFO pointers, occupancy and registered head entry
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    rd_nxt_c = rd_ptr_q + PTR_W'(1);
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_nxt_c;
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head comes from storage unless the pushed entry lands directly at the head
    if (pop_c && (count_q >= CNT_W'(2))) begin
      head_d = mem_q[rd_nxt_c];
    end else if (push_c && ((count_q == '0) || (pop_c && (count_q == CNT_W'(1))))) begin
      head_d = push_data_c;
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge REFCLK_3B0 or negedge FPGA_RST_n) begin
    if (!FPGA_RST_n) begin
      pb_level_q   <= '0;
      level_prev_q <= '0;
      pend_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      for (int i = 0; i < int'(NUM_PB); i++) begin
        db_cnt_q[i] <= '0;
        hold_q[i]   <= '0;
      end
    end else begin
      pb_level_q   <= pb_level_d;
      level_prev_q <= pb_level_q;
      pend_q       <= pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
      for (int i = 0; i < int'(NUM_PB); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        hold_q[i]   <= hold_d[i];
      end
    end
  end

  // Event storage; contents are qualified by the occupancy count
  always_ff @(posedge REFCLK_3B0) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= push_data_c;
    end
  end

  assign pb_level     = pb_level_q;
  assign evt_valid    = valid_q;
  assign evt_id       = head_q[ENT_W-1:2];
  assign evt_code     = head_q[1:0];
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_pb_event_decoder.sv
// Directed testbench for pb_event_decoder with short debounce/long-press times.
module tb_pb_event_decoder;

  localparam int unsigned NUM_PB = 2;
  localparam int unsigned ID_W   = 1;

  logic              clk;
  logic              rst_n;
  logic [NUM_PB-1:0] pb;
  logic [NUM_PB-1:0] pb_level;
  logic              evt_valid;
  logic              evt_ready;
  logic [ID_W-1:0]   evt_id;
  logic [1:0]        evt_code;
  logic              evt_overflow;
  logic              ovf_clear;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [ID_W+1:0] ev_q[$];
  int              cyc_q[$];
  logic            hi_seen;

  pb_event_decoder #(
    .NUM_PB           (2),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(16),
    .FIFO_DEPTH       (4)
  ) dut (
    .REFCLK_3B0  (clk),
    .FPGA_RST_n  (rst_n),
    .FPGA_PB     (pb),
    .pb_level    (pb_level),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_code    (evt_code),
    .evt_overflow(evt_overflow),
    .ovf_clear   (ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Log every accepted event with the cycle it was seen at the head
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      ev_q.push_back({evt_id, evt_code});
      cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    ev_q.delete();
    cyc_q.delete();
  endtask

  task automatic press_release(input int lo, input int hi);
    pb[0] = 1'b0;
    tick(lo);
    pb[0] = 1'b1;
    tick(hi);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    pb        = 2'b11;
    evt_ready = 1'b1;
    ovf_clear = 1'b0;
    hi_seen   = 1'b0;

    // Reset state
    tick(3);
    check("rst_level", 32'(pb_level), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_ovf", 32'(evt_overflow), 32'd0);
    check("rst_head", 32'({evt_id, evt_code}), 32'd0);
    rst_n = 1'b1;
    tick(10);
    check("post_rst_level", 32'(pb_level), 32'd0);
    check("post_rst_valid", 32'(evt_valid), 32'd0);
    check("post_rst_ovf", 32'(evt_overflow), 32'd0);
    check("post_rst_events", 32'(ev_q.size()), 32'd0);

    // Clean press / release with debounce latency of 6 cycles
    clear_log();
    pb[0] = 1'b0;
    tick(5);
    check("db_lat_5", 32'(pb_level[0]), 32'd0);
    tick(1);
    check("db_lat_6", 32'(pb_level[0]), 32'd1);
    tick(4);
    pb[0] = 1'b1;
    tick(20);
    check("clean_count", 32'(ev_q.size()), 32'd2);
    check("clean_ev0", 32'(ev_q[0]), 32'b0_01);
    check("clean_ev1", 32'(ev_q[1]), 32'b0_10);
    check("clean_level", 32'(pb_level), 32'd0);

    // Glitch rejection on button 1
    clear_log();
    for (int r = 0; r < 5; r++) begin
      pb[1] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        hi_seen = hi_seen | pb_level[1];
      end
      pb[1] = 1'b1;
      for (int c = 0; c < 2; c++) begin
        tick(1);
        hi_seen = hi_seen | pb_level[1];
      end
    end
    tick(10);
    check("glitch_level", 32'(hi_seen | pb_level[1]), 32'd0);
    check("glitch_events", 32'(ev_q.size()), 32'd0);

    // Long press: press, long 15 cycles after press at the head, release
    clear_log();
    pb[0] = 1'b0;
    tick(30);
    pb[0] = 1'b1;
    tick(30);
    check("long_count", 32'(ev_q.size()), 32'd3);
    check("long_ev0", 32'(ev_q[0]), 32'b0_01);
    check("long_ev1", 32'(ev_q[1]), 32'b0_11);
    check("long_ev2", 32'(ev_q[2]), 32'b0_10);
    check("long_delta", 32'(cyc_q[1] - cyc_q[0]), 32'd15);

    // Simultaneous buttons: button 0 first, consecutive pushes
    clear_log();
    pb = 2'b00;
    tick(10);
    pb = 2'b11;
    tick(20);
    check("simul_count", 32'(ev_q.size()), 32'd4);
    check("simul_ev0", 32'(ev_q[0]), 32'b0_01);
    check("simul_ev1", 32'(ev_q[1]), 32'b1_01);
    check("simul_delta", 32'(cyc_q[1] - cyc_q[0]), 32'd1);
    check("simul_ev2", 32'(ev_q[2]), 32'b0_10);
    check("simul_ev3", 32'(ev_q[3]), 32'b1_10);

    // Backpressure: fill the FIFO, then hold pending flags, then collide
    clear_log();
    evt_ready = 1'b0;
    press_release(8, 8);
    press_release(8, 8);
    tick(4);
    check("full_valid", 32'(evt_valid), 32'd1);
    check("full_head", 32'({evt_id, evt_code}), 32'b0_01);
    check("full_ovf", 32'(evt_overflow), 32'd0);
    press_release(8, 12);
    check("held_ovf", 32'(evt_overflow), 32'd0);
    check("held_head", 32'({evt_id, evt_code}), 32'b0_01);
    press_release(8, 12);
    check("ovf_set", 32'(evt_overflow), 32'd1);
    check("ovf_valid", 32'(evt_valid), 32'd1);
    check("ovf_head", 32'({evt_id, evt_code}), 32'b0_01);
    check("ovf_no_drain", 32'(ev_q.size()), 32'd0);
    ovf_clear = 1'b1;
    tick(1);
    ovf_clear = 1'b0;
    check("ovf_cleared", 32'(evt_overflow), 32'd0);
    tick(2);
    check("ovf_stays_clear", 32'(evt_overflow), 32'd0);
    evt_ready = 1'b1;
    tick(20);
    check("drain_count", 32'(ev_q.size()), 32'd6);
    check("drain_ev0", 32'(ev_q[0]), 32'b0_01);
    check("drain_ev1", 32'(ev_q[1]), 32'b0_10);
    check("drain_ev2", 32'(ev_q[2]), 32'b0_01);
    check("drain_ev3", 32'(ev_q[3]), 32'b0_10);
    check("drain_ev4", 32'(ev_q[4]), 32'b0_01);
    check("drain_ev5", 32'(ev_q[5]), 32'b0_10);
    check("drain_empty", 32'(evt_valid), 32'd0);

    // Asynchronous reset mid-operation with button held through release
    clear_log();
    evt_ready = 1'b0;
    pb[0] = 1'b0;
    tick(12);
    check("pre_rst_valid", 32'(evt_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(evt_valid), 32'd0);
    check("async_rst_level", 32'(pb_level), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    tick(5);
    check("redetect_5", 32'(pb_level[0]), 32'd0);
    tick(1);
    check("redetect_6", 32'(pb_level[0]), 32'd1);
    tick(6);
    check("redetect_count", 32'(ev_q.size()), 32'd1);
    check("redetect_ev0", 32'(ev_q[0]), 32'b0_01);
    pb[0] = 1'b1;
    tick(20);
    check("redetect_rel_count", 32'(ev_q.size()), 32'd2);
    check("redetect_ev1", 32'(ev_q[1]), 32'b0_10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
